user_entry: RTL
===============

# user_entry

Collects the player's four-digit guess from the board switches and push-buttons and presents it as a 16-bit BCD word, `user_int`, for comparison against the generated random number. It sits between the raw board inputs and the equality checker.

- The game controller pulses `arm` after the random number is shown.
- This block debounces the buttons and accepts digits one at a time, with backspace.
- It pulses `entry_done` when the guess is complete or entry has timed out.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required before a button level change is accepted.
- `TIMEOUT_CYCLES`, default 50_000_000: idle cycles in ENTRY before entry is abandoned.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `arm`  in  1  one-cycle pulse; starts or restarts an entry phase.
- `digit_sw`  in  4  switch value for the digit being entered.
- `btn_enter`  in  1  raw, asynchronous button; confirms `digit_sw` as the next digit.
- `btn_back`  in  1  raw, asynchronous button; deletes the last entered digit.
- `user_int`  out  16  entered guess.
  - First digit is at [15:12], second at [11:8], third at [7:4], fourth at [3:0].
  - Unentered nibbles read 4'hF.
- `digit_count`  out  3  digits currently entered, 0..4.
- `busy`  out  1  high while in ENTRY.
- `entry_done`  out  1  one-cycle pulse when ENTRY is left for DONE.
- `timed_out`  out  1  sticky; set when entry was abandoned by timeout.
- `err`  out  1  sticky; set when an enter press saw `digit_sw` > 9.

## Operation
Reset values (all registered):
- `user_int` = 16'hFFFF, `digit_count` = 0, `busy` = 0, `entry_done` = 0, `timed_out` = 0, `err` = 0.
- State = IDLE; debouncer levels = 0; timer = 0.

Button conditioning (one instance each for enter and back):
- Two-flop synchronizer, then a stability counter.
- When the synchronized level differs from the debounced level for `DEBOUNCE_CYCLES` consecutive cycles, the debounced level flips. Any mismatch-free cycle resets the counter.
- A press event is a 0->1 transition of the debounced level, lasting one cycle. Releases generate nothing.

State machine:
- **IDLE**
  - Press events are ignored.
  - `arm` -> ENTRY.
- **ENTRY** (`busy` = 1)
  - Enter event with `digit_sw` <= 9:
    - Write `digit_sw` into the nibble at position `digit_count`; increment `digit_count`; clear the timer.
    - If `digit_count` becomes 4 -> DONE.
  - Enter event with `digit_sw` > 9: set `err`; no write; count unchanged; clear the timer.
  - Back event with `digit_count` > 0: decrement `digit_count`; set that nibble to 4'hF; clear the timer.
  - Back event with `digit_count` = 0: no effect, except that the timer is cleared.
  - Enter and back events in the same cycle: both ignored; timer not cleared.
  - Timer reaches `TIMEOUT_CYCLES` - 1: set `timed_out` -> DONE. The partial `user_int` is held, and its 4'hF nibbles guarantee a mismatch against any valid BCD number.
  - `arm`: restart entry.
- **DONE**
  - `user_int` and the flags hold; press events are ignored.
  - `arm` -> ENTRY.

Entering ENTRY via `arm`, from any state:
- `user_int` = 16'hFFFF, `digit_count` = 0, `err` = 0, `timed_out` = 0, timer = 0.
- `arm` has priority over any press event in the same cycle; that event is discarded.

`entry_done` rules:
- Asserted for exactly the one cycle in which the state register first reads DONE.
- Never asserted on an `arm`-driven restart.

## Timing
- With `btn_enter` raw high and stable from before edge 0:
  - Synchronizer output is high at edge 2.
  - Debounced level rises at edge `DEBOUNCE_CYCLES` + 2.
  - `user_int` and `digit_count` update at edge `DEBOUNCE_CYCLES` + 3.
- The `btn_back` path has identical latency.
- `arm` sampled at edge N -> `busy` = 1 and cleared outputs visible after edge N.
- Fourth accepted digit:
  - `digit_count` = 4 and `user_int` final in the same cycle that `entry_done` = 1 and `busy` = 0.
  - `entry_done` = 0 from the next cycle.
- Timeout fires `TIMEOUT_CYCLES` edges after the last timer clear. `entry_done` and `timed_out` rise together.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no event.
- Holding a button produces exactly one event.
- `rst` asserted at any time forces all reset values immediately, including mid-debounce and mid-entry.

## Test plan
- **Normal entry:** reset, `arm`, then enter presses with `digit_sw` = 3, 7, 0, 9.
  - `user_int` = 16'h3709, `digit_count` = 4.
  - One `entry_done` pulse; `err` = 0, `timed_out` = 0.
- **Backspace:** `arm`, then enter 5, enter 2, back, enter 8, enter 1, enter 4.
  - After back: `user_int` = 16'h5FFF.
  - Final: `user_int` = 16'h5814 with `entry_done`.
- **Invalid digit:** `arm`, enter with `digit_sw` = 4'hC.
  - `err` = 1, `digit_count` = 0, `user_int` = 16'hFFFF.
  - A following enter of 6 gives 16'h6FFF, with `err` still 1.
- **Bounce:** on `btn_enter`, glitch high for `DEBOUNCE_CYCLES` - 1 cycles -> no digit.
  - Then hold high for 3×`DEBOUNCE_CYCLES` -> exactly one digit accepted.
- **Timeout:** `TIMEOUT_CYCLES` = 100; `arm`, enter 2, then idle for 100 cycles.
  - `timed_out` = 1, `entry_done` pulse, `user_int` = 16'h2FFF.
  - Later presses are ignored.
- **Re-arm and reset:** `arm` mid-entry with `user_int` = 16'h12FF -> 16'hFFFF, count 0, no `entry_done`.
  - `rst` asserted while in DONE -> all outputs at reset values.
  - Subsequent presses are ignored until `arm`.

Source files
------------

// File: rtl/user_entry.sv
// Purpose: debounce enter/back buttons and assemble a four-digit BCD guess after arm.
// Latency: a button press updates user_int/digit_count DEBOUNCE_CYCLES+3 edges after the raw level first rises.
// Backpressure: none; presses outside ENTRY, or enter+back in the same cycle, are dropped.
module user_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic [3:0]  digit_sw,
  input  logic        btn_enter,
  input  logic        btn_back,
  output logic [15:0] user_int,
  output logic [2:0]  digit_count,
  output logic        busy,
  output logic        entry_done,
  output logic        timed_out,
  output logic        err
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Button conditioning: bit 0 is the enter button, bit 1 is the back button.
  logic [1:0]     sync1_q, sync1_d;
  logic [1:0]     sync2_q, sync2_d;
  logic [1:0]     deb_q, deb_d;
  logic [1:0]     deb_prev_q, deb_prev_d;
  logic [DCW-1:0] dcnt_q [2];
  logic [DCW-1:0] dcnt_d [2];
  logic [1:0]     press;
  logic           enter_ev;
  logic           back_ev;

  // Entry state machine and its registered outputs.
  state_t         state_q, state_d;
  logic [15:0]    user_int_q, user_int_d;
  logic [2:0]     digit_count_q, digit_count_d;
  logic           busy_q, busy_d;
  logic           entry_done_q, entry_done_d;
  logic           timed_out_q, timed_out_d;
  logic           err_q, err_d;
  logic [TW-1:0]  timer_q, timer_d;

  // Nibble positions: digit n lives at bits [15-4n -: 4], i.e. lsb = (3-n)*4.
  logic [3:0]     wr_lsb;
  logic [1:0]     bk_pos;
  logic [3:0]     bk_lsb;

  // Synchronize the raw buttons and flip each debounced level only after a full run of mismatches.
  always_comb begin
    sync1_d    = {btn_back, btn_enter};
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    dcnt_d     = dcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          deb_d[i]  = sync2_q[i];
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end else begin
        dcnt_d[i] = '0;
      end
    end
  end

  // Register the synchronizer, debounced levels and stability counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      dcnt_q[0]  <= '0;
      dcnt_q[1]  <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      dcnt_q     <= dcnt_d;
    end
  end

  // A press is the single cycle after the debounced level rises; releases are silent.
  assign press    = deb_q & ~deb_prev_q;
  assign enter_ev = press[0];
  assign back_ev  = press[1];

  assign wr_lsb = {~digit_count_q[1:0], 2'b00};
  assign bk_pos = digit_count_q[1:0] - 2'd1;
  assign bk_lsb = {~bk_pos, 2'b00};

  // Next-state logic: arm wins over everything; in ENTRY a lone press is served, else the idle timer runs.
  always_comb begin
    state_d       = state_q;
    user_int_d    = user_int_q;
    digit_count_d = digit_count_q;
    entry_done_d  = 1'b0;
    timed_out_d   = timed_out_q;
    err_d         = err_q;
    timer_d       = timer_q;

    if (arm) begin
      state_d       = S_ENTRY;
      user_int_d    = 16'hFFFF;
      digit_count_d = 3'd0;
      err_d         = 1'b0;
      timed_out_d   = 1'b0;
      timer_d       = '0;
    end else begin
      case (state_q)
        S_ENTRY: begin
          if (enter_ev && !back_ev) begin
            timer_d = '0;
            if (digit_sw <= 4'd9) begin
              user_int_d[wr_lsb +: 4] = digit_sw;
              digit_count_d           = digit_count_q + 3'd1;
              if (digit_count_q == 3'd3) begin
                state_d      = S_DONE;
                entry_done_d = 1'b1;
              end
            end else begin
              err_d = 1'b1;
            end
          end else if (back_ev && !enter_ev) begin
            timer_d = '0;
            if (digit_count_q != 3'd0) begin
              digit_count_d           = digit_count_q - 3'd1;
              user_int_d[bk_lsb +: 4] = 4'hF;
            end
          end else if (timer_q == TO_LAST) begin
            // Partial guess is kept; its 4'hF nibbles can never equal valid BCD.
            timed_out_d  = 1'b1;
            state_d      = S_DONE;
            entry_done_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    busy_d = (state_d == S_ENTRY);
  end

  // Entry state and all outputs are registered together so they change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      user_int_q    <= 16'hFFFF;
      digit_count_q <= 3'd0;
      busy_q        <= 1'b0;
      entry_done_q  <= 1'b0;
      timed_out_q   <= 1'b0;
      err_q         <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      user_int_q    <= user_int_d;
      digit_count_q <= digit_count_d;
      busy_q        <= busy_d;
      entry_done_q  <= entry_done_d;
      timed_out_q   <= timed_out_d;
      err_q         <= err_d;
      timer_q       <= timer_d;
    end
  end

  assign user_int    = user_int_q;
  assign digit_count = digit_count_q;
  assign busy        = busy_q;
  assign entry_done  = entry_done_q;
  assign timed_out   = timed_out_q;
  assign err         = err_q;

endmodule
